// File: rtl/xgbe_rx_dispatch_nch.sv
// xgbe_rx_dispatch_nch
//   Routes each frame of the XGBE MAC Rx AXI-Stream to one or more of NUM_CH
//   registered output streams, selected by the destination MAC on the first beat.
//   Broadcast frames are round-robined or replicated. Unmatched frames go to a
//   miss channel or are dropped. Per-channel frame counters and a drop counter
//   are maintained.
// Ports:
//   xgemac_clk_156 / xgbe_mac_reset : clock, async active-high reset
//   ch_mac_addr, ch_tdest, ch_en    : per-channel unicast MAC, tdest tag, enable
//   bcast_en, bcast_mode            : broadcast eligibility, 0=round-robin 1=replicate
//   miss_en, miss_ch                : unmatched-frame channel (or drop)
//   s_t*                            : MAC Rx stream in
//   m_t*                            : flattened per-channel output streams
//   pkt_cnt, drop_cnt               : delivered frames per channel, dropped frames
module xgbe_rx_dispatch_nch #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TDEST_W = 3
) (
  input  logic                        xgemac_clk_156,
  input  logic                        xgbe_mac_reset,
  input  logic [48*NUM_CH-1:0]        ch_mac_addr,
  input  logic [TDEST_W*NUM_CH-1:0]   ch_tdest,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH-1:0]           bcast_en,
  input  logic                        bcast_mode,
  input  logic                        miss_en,
  input  logic [2:0]                  miss_ch,
  input  logic [DATA_W-1:0]           s_tdata,
  input  logic [DATA_W/8-1:0]         s_tkeep,
  input  logic                        s_tlast,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic [NUM_CH*DATA_W-1:0]    m_tdata,
  output logic [NUM_CH*DATA_W/8-1:0]  m_tkeep,
  output logic [NUM_CH-1:0]           m_tlast,
  output logic [NUM_CH-1:0]           m_tvalid,
  output logic [NUM_CH*TDEST_W-1:0]   m_tdest,
  input  logic [NUM_CH-1:0]           m_tready,
  output logic [32*NUM_CH-1:0]        pkt_cnt,
  output logic [31:0]                 drop_cnt
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_FIRST, ST_FWD, ST_DROP} state_e;

  state_e                       state_q, state_d;
  logic [NUM_CH-1:0]            sel_mask_q, sel_mask_d;
  logic                         rr_frame_q, rr_frame_d;
  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [31:0]                  drop_cnt_q, drop_cnt_d;
  logic [32*NUM_CH-1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [NUM_CH*DATA_W-1:0]     m_tdata_q, m_tdata_d;
  logic [NUM_CH*KEEP_W-1:0]     m_tkeep_q, m_tkeep_d;
  logic [NUM_CH-1:0]            m_tlast_q, m_tlast_d;
  logic [NUM_CH-1:0]            m_tvalid_q, m_tvalid_d;
  logic [NUM_CH*TDEST_W-1:0]    m_tdest_q, m_tdest_d;

  logic [NUM_CH-1:0]            rr_sel, uc_sel, first_sel, cur_sel;
  logic                         rr_found, uc_hit, is_bcast, rr_hit;
  logic                         drop_path, room, accept;

  // First-beat route decision: broadcast, then unicast, then miss.
  always_comb begin : route_c
    int unsigned idx;
    idx      = 0;
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!rr_found && bcast_en[idx]) begin
        rr_sel[idx] = 1'b1;
        rr_found    = 1'b1;
      end
    end
    uc_sel = '0;
    uc_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!uc_hit && ch_en[i] && (ch_mac_addr[48*i +: 48] == s_tdata[47:0])) begin
        uc_sel[i] = 1'b1;
        uc_hit    = 1'b1;
      end
    end
    is_bcast  = &s_tdata[47:0];
    first_sel = '0;
    if (is_bcast) begin
      first_sel = bcast_mode ? bcast_en : rr_sel;
    end else if (uc_hit) begin
      first_sel = uc_sel;
    end else if (miss_en) begin
      // Out-of-range miss_ch matches no channel, leaving the frame dropped.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (32'(miss_ch) == i) first_sel[i] = 1'b1;
      end
    end
  end

  // Ready only waits on the channels this beat is actually written into.
  always_comb begin
    drop_path = (state_q == ST_DROP) || ((state_q == ST_FIRST) && (first_sel == '0));
    cur_sel   = (state_q == ST_FIRST) ? first_sel : sel_mask_q;
    room      = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_sel[i] && m_tvalid_q[i] && !m_tready[i]) room = 1'b0;
    end
    s_tready = !xgbe_mac_reset && (drop_path || room);
    accept   = s_tvalid && s_tready;
  end

  always_comb begin
    state_d    = state_q;
    sel_mask_d = sel_mask_q;
    rr_frame_d = rr_frame_q;
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    rr_hit     = (state_q == ST_FIRST) ? (is_bcast && !bcast_mode && rr_found) : rr_frame_q;
    if (accept) begin
      if (state_q == ST_FIRST) begin
        sel_mask_d = first_sel;
        rr_frame_d = rr_hit;
      end
      if (s_tlast) begin
        state_d = ST_FIRST;
        if (drop_path && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
        if (rr_hit && !drop_path) begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cur_sel[k]) rr_ptr_d = (k + 1 == NUM_CH) ? '0 : PTR_W'(k + 1);
          end
        end
      end else if (state_q == ST_FIRST) begin
        state_d = drop_path ? ST_DROP : ST_FWD;
      end
    end
  end

  // Per-channel 1-deep output register; load wins over drain in the same cycle.
  // tdest is taken only on the first beat, so mid-frame ch_tdest changes are ignored.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tdest_d  = m_tdest_q;
    m_tvalid_d = m_tvalid_q & ~m_tready;
    pkt_cnt_d  = pkt_cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (accept && !drop_path && cur_sel[i]) begin
        m_tvalid_d[i]                = 1'b1;
        m_tdata_d[i*DATA_W +: DATA_W] = s_tdata;
        m_tkeep_d[i*KEEP_W +: KEEP_W] = s_tkeep;
        m_tlast_d[i]                 = s_tlast;
        if (state_q == ST_FIRST) m_tdest_d[i*TDEST_W +: TDEST_W] = ch_tdest[i*TDEST_W +: TDEST_W];
      end
      if (m_tvalid_q[i] && m_tready[i] && m_tlast_q[i]) begin
        pkt_cnt_d[i*32 +: 32] = pkt_cnt_q[i*32 +: 32] + 32'd1;
      end
    end
  end

  always_ff @(posedge xgemac_clk_156 or posedge xgbe_mac_reset) begin
    if (xgbe_mac_reset) begin
      state_q    <= ST_FIRST;
      sel_mask_q <= '0;
      rr_frame_q <= 1'b0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= '0;
      m_tvalid_q <= '0;
      m_tdest_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_mask_q <= sel_mask_d;
      rr_frame_q <= rr_frame_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdest_q  <= m_tdest_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdest  = m_tdest_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_xgbe_rx_dispatch_nch.sv
// Testbench for xgbe_rx_dispatch_nch (NUM_CH=3, DATA_W=64, TDEST_W=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_xgbe_rx_dispatch_nch;

  localparam logic [47:0] A0  = 48'h0200_0000_0A00;
  localparam logic [47:0] A1  = 48'h0200_0000_0A01;
  localparam logic [47:0] A2  = 48'h0200_0000_0A02;
  localparam logic [47:0] UNK = 48'h0200_0000_0BEE;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;

  logic         clk, rst;
  logic [143:0] ch_mac_addr;
  logic [8:0]   ch_tdest;
  logic [2:0]   ch_en, bcast_en, miss_ch, m_tready;
  logic         bcast_mode, miss_en;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         s_tlast, s_tvalid, s_tready;
  logic [191:0] m_tdata;
  logic [23:0]  m_tkeep;
  logic [2:0]   m_tlast, m_tvalid;
  logic [8:0]   m_tdest;
  logic [95:0]  pkt_cnt;
  logic [31:0]  drop_cnt;

  logic [2:0]   td [3];
  int unsigned  exp_pkt [3];
  int unsigned  exp_drop;
  int           n_tests, n_fail;

  typedef struct {
    logic [47:0] dest;
    logic [2:0]  ch_en;
    logic [2:0]  bc_en;
    logic        bc_mode;
    logic        m_en;
    logic [2:0]  m_ch;
    logic [2:0]  exp_v;
  } vec_t;
  vec_t vecs [16];

  xgbe_rx_dispatch_nch #(.NUM_CH(3), .DATA_W(64), .TDEST_W(3)) dut (
    .xgemac_clk_156(clk), .xgbe_mac_reset(rst),
    .ch_mac_addr(ch_mac_addr), .ch_tdest(ch_tdest), .ch_en(ch_en),
    .bcast_en(bcast_en), .bcast_mode(bcast_mode), .miss_en(miss_en), .miss_ch(miss_ch),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tdest(m_tdest), .m_tready(m_tready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [2:0] en, input logic [2:0] bce, input logic bcm,
                         input logic men, input logic [2:0] mch);
    ch_en = en; bcast_en = bce; bcast_mode = bcm; miss_en = men; miss_ch = mch;
  endtask

  // Present one beat, require ready, and advance past the accepting edge.
  task automatic drive_beat(input logic [63:0] d, input bit last, input string nm);
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    s_tkeep = last ? 8'h3F : 8'hFF;
    #1;
    check({nm, " s_tready"}, 64'(s_tready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string nm, input logic [2:0] ev, input logic [63:0] d, input bit last);
    check({nm, " m_tvalid"}, 64'(m_tvalid), 64'(ev));
    for (int i = 0; i < 3; i++) begin
      if (ev[i]) begin
        check($sformatf("%s ch%0d tdata", nm, i), m_tdata[i*64 +: 64], d);
        check($sformatf("%s ch%0d tlast", nm, i), 64'(m_tlast[i]), 64'(last));
        check($sformatf("%s ch%0d tkeep", nm, i), 64'(m_tkeep[i*8 +: 8]), last ? 64'h3F : 64'hFF);
        check($sformatf("%s ch%0d tdest", nm, i), 64'(m_tdest[i*3 +: 3]), 64'(td[i]));
      end
    end
  endtask

  task automatic check_cnt(input string nm);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s pkt_cnt%0d", nm, i), 64'(pkt_cnt[i*32 +: 32]), 64'(exp_pkt[i]));
    check({nm, " drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic idle_cycle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] d, d2;
    logic [2:0]  rr_exp [3];
    n_tests = 0; n_fail = 0; exp_drop = 0;
    for (int i = 0; i < 3; i++) exp_pkt[i] = 0;
    td[0] = 3'd5; td[1] = 3'd3; td[2] = 3'd6;
    ch_mac_addr = {A2, A1, A0};
    ch_tdest    = {td[2], td[1], td[0]};
    set_cfg(3'b111, 3'b000, 1'b0, 1'b0, 3'd0);
    m_tready = 3'b111;
    s_tdata = {16'h0, A2}; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    rst = 1'b1;

    // name, dest, ch_en, bcast_en, mode, miss_en, miss_ch -> expected m_tvalid
    vecs[0]  = '{A1,  3'b111, 3'b000, 1'b0, 1'b0, 3'd0, 3'b010};
    vecs[1]  = '{A0,  3'b111, 3'b000, 1'b0, 1'b0, 3'd0, 3'b001};
    vecs[2]  = '{A2,  3'b011, 3'b000, 1'b0, 1'b0, 3'd0, 3'b000};
    vecs[3]  = '{UNK, 3'b111, 3'b000, 1'b0, 1'b1, 3'd2, 3'b100};
    vecs[4]  = '{UNK, 3'b111, 3'b000, 1'b0, 1'b1, 3'd3, 3'b000};
    vecs[5]  = '{UNK, 3'b111, 3'b000, 1'b0, 1'b1, 3'd7, 3'b000};
    vecs[6]  = '{BC,  3'b111, 3'b110, 1'b1, 1'b0, 3'd0, 3'b110};
    vecs[7]  = '{BC,  3'b111, 3'b000, 1'b1, 1'b1, 3'd2, 3'b000};
    vecs[8]  = '{BC,  3'b111, 3'b111, 1'b0, 1'b0, 3'd0, 3'b001};
    vecs[9]  = '{BC,  3'b111, 3'b111, 1'b0, 1'b0, 3'd0, 3'b010};
    vecs[10] = '{BC,  3'b111, 3'b101, 1'b0, 1'b0, 3'd0, 3'b100};
    vecs[11] = '{BC,  3'b111, 3'b110, 1'b0, 1'b0, 3'd0, 3'b010};
    vecs[12] = '{BC,  3'b111, 3'b011, 1'b0, 1'b0, 3'd0, 3'b001};
    vecs[13] = '{BC,  3'b111, 3'b000, 1'b0, 1'b0, 3'd0, 3'b000};
    vecs[14] = '{A1,  3'b101, 3'b000, 1'b0, 1'b1, 3'd0, 3'b001};
    vecs[15] = '{A2,  3'b111, 3'b111, 1'b0, 1'b1, 3'd1, 3'b100};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset s_tready", 64'(s_tready), 64'd0);
    check("reset m_tvalid", 64'(m_tvalid), 64'd0);
    check("reset m_tdata nonzero", 64'(m_tdata != '0), 64'd0);
    check("reset m_tkeep/tlast/tdest nonzero", 64'((m_tkeep != '0) || (m_tlast != '0) || (m_tdest != '0)), 64'd0);
    check_cnt("reset");
    rst = 1'b0;
    s_tvalid = 1'b0;

    // Single-beat frames back to back: routing table, no bubbles
    for (int v = 0; v < 16; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      set_cfg(vecs[v].ch_en, vecs[v].bc_en, vecs[v].bc_mode, vecs[v].m_en, vecs[v].m_ch);
      d = {8'(v), 8'hA5, vecs[v].dest};
      drive_beat(d, 1'b1, nm);
      for (int i = 0; i < 3; i++) if (vecs[v].exp_v[i]) exp_pkt[i]++;
      if (vecs[v].exp_v == 3'b000) exp_drop++;
      check_out(nm, vecs[v].exp_v, d, 1'b1);
      check({nm, " drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    end
    idle_cycle();
    check("vec drain m_tvalid", 64'(m_tvalid), 64'd0);
    check_cnt("vec end");

    // 4-beat unicast to ch1; config changes mid-frame must not matter
    set_cfg(3'b111, 3'b000, 1'b0, 1'b0, 3'd0);
    drive_beat({16'h1111, A1}, 1'b0, "uc b0");
    check_out("uc b0", 3'b010, {16'h1111, A1}, 1'b0);
    set_cfg(3'b000, 3'b111, 1'b1, 1'b1, 3'd0);
    ch_tdest = '0;
    drive_beat({16'h2222, A0}, 1'b0, "uc b1");
    check_out("uc b1", 3'b010, {16'h2222, A0}, 1'b0);
    drive_beat({16'h3333, BC}, 1'b0, "uc b2");
    check_out("uc b2", 3'b010, {16'h3333, BC}, 1'b0);
    drive_beat({16'h4444, UNK}, 1'b1, "uc b3");
    check_out("uc b3", 3'b010, {16'h4444, UNK}, 1'b1);
    set_cfg(3'b111, 3'b000, 1'b0, 1'b0, 3'd0);
    ch_tdest = {td[2], td[1], td[0]};
    idle_cycle();
    exp_pkt[1]++;
    check("uc drain m_tvalid", 64'(m_tvalid), 64'd0);
    check_cnt("uc end");

    // Reset during beat 2 of 4; tail is re-routed by its own first beat
    drive_beat({16'h5001, A1}, 1'b0, "rst b0");
    drive_beat({16'h5002, A2}, 1'b0, "rst b1");
    check_out("rst b1", 3'b010, {16'h5002, A2}, 1'b0);
    rst = 1'b1;
    #1;
    exp_drop = 0;
    for (int i = 0; i < 3; i++) exp_pkt[i] = 0;
    check("midrst s_tready", 64'(s_tready), 64'd0);
    check("midrst m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst m_tdata nonzero", 64'(m_tdata != '0), 64'd0);
    check_cnt("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    drive_beat({16'h5003, A0}, 1'b0, "post b2");
    check_out("post b2", 3'b001, {16'h5003, A0}, 1'b0);
    drive_beat({16'h5004, UNK}, 1'b1, "post b3");
    check_out("post b3", 3'b001, {16'h5004, UNK}, 1'b1);
    idle_cycle();
    exp_pkt[0]++;
    check_cnt("post rst");

    // Round-robin broadcast from rr_ptr=0 over bcast_en=101
    set_cfg(3'b111, 3'b101, 1'b0, 1'b0, 3'd0);
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b100; rr_exp[2] = 3'b001;
    for (int f = 0; f < 3; f++) begin
      d  = {8'(f), 8'hB0, BC};
      d2 = {16'hC0DE, A1};
      drive_beat(d, 1'b0, $sformatf("rr f%0d b0", f));
      check_out($sformatf("rr f%0d b0", f), rr_exp[f], d, 1'b0);
      drive_beat(d2, 1'b1, $sformatf("rr f%0d b1", f));
      check_out($sformatf("rr f%0d b1", f), rr_exp[f], d2, 1'b1);
      for (int i = 0; i < 3; i++) if (rr_exp[f][i]) exp_pkt[i]++;
    end
    // rr_ptr should now be 1: a broadcast over all channels lands on ch1
    set_cfg(3'b111, 3'b111, 1'b0, 1'b0, 3'd0);
    drive_beat({16'hB0B0, BC}, 1'b1, "rr probe");
    check_out("rr probe", 3'b010, {16'hB0B0, BC}, 1'b1);
    exp_pkt[1]++;
    idle_cycle();
    check_cnt("rr end");

    // Replicate to ch0/ch1 with ch1 stalled for 5 cycles
    set_cfg(3'b111, 3'b011, 1'b1, 1'b0, 3'd0);
    m_tready = 3'b101;
    drive_beat({16'hE000, BC}, 1'b0, "rep b0");
    check_out("rep b0", 3'b011, {16'hE000, BC}, 1'b0);
    s_tdata = {16'hE001, A2}; s_tlast = 1'b1; s_tkeep = 8'h3F;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("rep stall%0d s_tready", c), 64'(s_tready), 64'd0);
      check($sformatf("rep stall%0d ch1 valid", c), 64'(m_tvalid[1]), 64'd1);
      check($sformatf("rep stall%0d ch1 data", c), m_tdata[64 +: 64], {16'hE000, BC});
      if (c > 0) check($sformatf("rep stall%0d ch0 valid", c), 64'(m_tvalid[0]), 64'd0);
      @(posedge clk); #1;
    end
    m_tready = 3'b111;
    #1;
    check("rep release s_tready", 64'(s_tready), 64'd1);
    @(posedge clk); #1;
    check_out("rep b1", 3'b011, {16'hE001, A2}, 1'b1);
    exp_pkt[0]++; exp_pkt[1]++;
    idle_cycle();
    check_cnt("rep end");

    // Miss to ch2, then miss dropped with all outputs stalled
    set_cfg(3'b111, 3'b000, 1'b0, 1'b1, 3'd2);
    for (int b = 0; b < 3; b++) begin
      d = {8'(b), 8'hD0, UNK};
      drive_beat(d, b == 2, $sformatf("miss b%0d", b));
      check_out($sformatf("miss b%0d", b), 3'b100, d, b == 2);
    end
    exp_pkt[2]++;
    idle_cycle();
    set_cfg(3'b111, 3'b000, 1'b0, 1'b0, 3'd0);
    m_tready = 3'b000;
    for (int b = 0; b < 3; b++) begin
      d = {8'(b), 8'hDD, UNK};
      drive_beat(d, b == 2, $sformatf("drop b%0d", b));
      if (b == 2) exp_drop++;
      check($sformatf("drop b%0d m_tvalid", b), 64'(m_tvalid), 64'd0);
      check($sformatf("drop b%0d drop_cnt", b), 64'(drop_cnt), 64'(exp_drop));
      set_cfg(3'b111, 3'b000, 1'b0, 1'b1, 3'd0);
    end
    m_tready = 3'b111;
    idle_cycle();
    check_cnt("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
